// File: rtl/ringbuf_reader.sv
// Consumer side of the one-hot ring buffer: pops head entries into a 2-deep
// registered output queue that feeds a valid/ready stream.
module ringbuf_reader #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_empty,
  input  logic             i_overflow,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_re,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic             o_err,
  output logic [CNTW-1:0]  o_count
);

  logic [1:0][WIDTH-1:0] q_reg, q_next;
  logic [1:0]            cnt_reg, cnt_next;
  logic                  err_reg;
  logic [CNTW-1:0]       popcnt_reg;
  logic                  enq, deq;

  assign o_valid = (cnt_reg != 2'd0);
  assign o_data  = q_reg[0];
  assign o_err   = err_reg;
  assign o_count = popcnt_reg;
  assign deq     = o_valid & i_ready;

  // A full queue can still pop when the head entry leaves this cycle.
  assign o_re = ~i_rst & ~i_empty & ~i_flush & ~i_overflow &
                ((cnt_reg != 2'd2) | deq);
  assign enq  = o_re;

  always_comb begin
    q_next   = q_reg;
    cnt_next = cnt_reg;
    if (i_flush) begin
      cnt_next = 2'd0;
    end else begin
      case ({enq, deq})
        2'b10: begin
          q_next[cnt_reg[0]] = i_data;
          cnt_next           = cnt_reg + 2'd1;
        end
        2'b01: begin
          q_next[0] = q_reg[1];
          cnt_next  = cnt_reg - 2'd1;
        end
        2'b11: begin
          if (cnt_reg == 2'd2) begin
            q_next[0] = q_reg[1];
            q_next[1] = i_data;
          end else begin
            q_next[0] = i_data;
          end
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) q_reg[gi] <= '0;
        else       q_reg[gi] <= q_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_reg    <= 2'd0;
      err_reg    <= 1'b0;
      popcnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      if (i_overflow) err_reg <= 1'b1;
      if (o_re) popcnt_reg <= popcnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_ringbuf_reader.sv
// Self-checking bench for ringbuf_reader: vector table, directed corner cases
// and randomized traffic against a queue-based reference model.
module tb_ringbuf_reader;

  logic        i_clk = 1'b0;
  logic        i_rst, i_empty, i_overflow, i_ready, i_flush;
  logic [3:0]  i_data;
  logic        o_re, o_valid, o_err;
  logic [3:0]  o_data;
  logic [15:0] o_count;

  ringbuf_reader #(.WIDTH(4), .CNTW(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_empty(i_empty), .i_overflow(i_overflow),
    .i_data(i_data), .o_re(o_re), .o_valid(o_valid), .o_data(o_data),
    .i_ready(i_ready), .i_flush(i_flush), .o_err(o_err), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  logic [3:0]  src[$];   // ring buffer contents, head at index 0
  logic [3:0]  mq[$];    // model of the entries held by the reader
  logic [3:0]  rx[$];    // entries accepted downstream
  logic        m_err;
  logic [15:0] m_cnt;

  logic        s_re, s_valid;
  logic [3:0]  s_data;
  logic [15:0] s_count;

  typedef struct {
    logic        rdy;
    logic        e_re;
    logic        e_valid;
    logic [3:0]  e_data;
    logic [15:0] e_count;
  } vec_t;
  vec_t vec[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_err = 1'b0;
    m_cnt = '0;
  endtask

  // One clock: drive inputs, sample and compare at negedge, advance at posedge.
  task automatic cycle(input logic rdy, input logic fl, input logic ov);
    logic       e_valid, e_re;
    logic [3:0] e_data, head;
    i_ready    = rdy;
    i_flush    = fl;
    i_overflow = ov;
    i_empty    = (src.size() == 0);
    head       = (src.size() != 0) ? src[0] : 4'd0;
    i_data     = head;
    @(negedge i_clk);
    e_valid = (mq.size() > 0);
    e_data  = e_valid ? mq[0] : 4'd0;
    e_re    = !i_empty && !fl && !ov && ((mq.size() < 2) || (e_valid && rdy));
    s_re = o_re; s_valid = o_valid; s_data = o_data; s_count = o_count;
    chk("model_re", {31'd0, o_re}, {31'd0, e_re});
    chk("model_valid", {31'd0, o_valid}, {31'd0, e_valid});
    if (e_valid) chk("model_data", {28'd0, o_data}, {28'd0, e_data});
    chk("model_err", {31'd0, o_err}, {31'd0, m_err});
    chk("model_count", {16'd0, o_count}, {16'd0, m_cnt});
    if (o_valid && rdy) rx.push_back(o_data);
    $display("t=%0t rdy=%0b fl=%0b ov=%0b empty=%0b re=%0b valid=%0b data=%0h err=%0b count=%0d",
             $time, rdy, fl, ov, i_empty, o_re, o_valid, o_data, o_err, o_count);
    @(posedge i_clk);
    #1;
    if (fl) mq.delete();
    else begin
      if (e_valid && rdy) void'(mq.pop_front());
      if (e_re) mq.push_back(head);
    end
    if (ov) m_err = 1'b1;
    if (e_re) m_cnt = m_cnt + 16'd1;
    if (s_re && src.size() != 0) void'(src.pop_front());
  endtask

  initial begin
    vec[0]  = '{1'b1, 1'b1, 1'b0, 4'd0, 16'd0};
    vec[1]  = '{1'b1, 1'b1, 1'b1, 4'd3, 16'd1};
    vec[2]  = '{1'b1, 1'b1, 1'b1, 4'd5, 16'd2};
    vec[3]  = '{1'b1, 1'b0, 1'b1, 4'd7, 16'd3};
    vec[4]  = '{1'b1, 1'b0, 1'b0, 4'd0, 16'd3};
    vec[5]  = '{1'b0, 1'b1, 1'b0, 4'd0, 16'd3};
    vec[6]  = '{1'b0, 1'b1, 1'b1, 4'd1, 16'd4};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 4'd1, 16'd5};
    vec[8]  = '{1'b0, 1'b0, 1'b1, 4'd1, 16'd5};
    vec[9]  = '{1'b1, 1'b1, 1'b1, 4'd1, 16'd5};
    vec[10] = '{1'b1, 1'b1, 1'b1, 4'd2, 16'd6};
    vec[11] = '{1'b1, 1'b0, 1'b1, 4'd3, 16'd7};
    vec[12] = '{1'b1, 1'b0, 1'b1, 4'd4, 16'd7};
    vec[13] = '{1'b1, 1'b0, 1'b0, 4'd0, 16'd7};

    i_rst = 1'b1; i_empty = 1'b1; i_overflow = 1'b0; i_ready = 1'b0;
    i_flush = 1'b0; i_data = 4'd0;
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_re", {31'd0, o_re}, 32'd0);
    chk("reset_data", {28'd0, o_data}, 32'd0);
    chk("reset_err", {31'd0, o_err}, 32'd0);
    chk("reset_count", {16'd0, o_count}, 32'd0);
    @(posedge i_clk); #2;
    i_rst = 1'b0;

    // Vector table: 3,5,7 streamed with ready high, then 1..4 under back-pressure.
    src = '{4'd3, 4'd5, 4'd7};
    for (int i = 0; i < 14; i++) begin
      if (i == 5) src = '{4'd1, 4'd2, 4'd3, 4'd4};
      cycle(vec[i].rdy, 1'b0, 1'b0);
      chk($sformatf("vec%0d_re", i), {31'd0, s_re}, {31'd0, vec[i].e_re});
      chk($sformatf("vec%0d_valid", i), {31'd0, s_valid}, {31'd0, vec[i].e_valid});
      if (vec[i].e_valid)
        chk($sformatf("vec%0d_data", i), {28'd0, s_data}, {28'd0, vec[i].e_data});
      chk($sformatf("vec%0d_count", i), {16'd0, s_count}, {16'd0, vec[i].e_count});
    end

    // Ready toggling over a 16-entry stream.
    begin
      logic [15:0] c0;
      int budget;
      rx.delete();
      for (int v = 0; v < 16; v++) src.push_back(v[3:0]);
      c0 = m_cnt;
      budget = 0;
      while (rx.size() < 16 && budget < 200) begin
        cycle(budget[0] == 1'b0, 1'b0, 1'b0);
        budget++;
      end
      chk("toggle_len", rx.size(), 32'd16);
      for (int v = 0; v < 16 && v < rx.size(); v++)
        chk($sformatf("toggle_item%0d", v), {28'd0, rx[v]}, v);
      cycle(1'b0, 1'b0, 1'b0);
      chk("toggle_count", {16'd0, s_count}, {16'd0, c0 + 16'd16});
    end

    // Flush with a full queue and a non-empty buffer.
    begin
      logic [15:0] c0;
      src = '{4'd10, 4'd11, 4'd12, 4'd13};
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      c0 = s_count;
      cycle(1'b1, 1'b1, 1'b0);
      chk("flush_re", {31'd0, s_re}, 32'd0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("flush_valid_next", {31'd0, s_valid}, 32'd0);
      chk("flush_count", {16'd0, s_count}, {16'd0, c0});
      chk("flush_pop", {31'd0, s_re}, 32'd1);
      cycle(1'b1, 1'b0, 1'b0);
      chk("flush_next_data", {28'd0, s_data}, 32'd12);
      chk("flush_next_valid", {31'd0, s_valid}, 32'd1);
    end

    // Single-cycle overflow: pop gated, sticky error.
    src.push_back(4'd6);
    cycle(1'b1, 1'b0, 1'b1);
    chk("ovf_re", {31'd0, s_re}, 32'd0);
    repeat (4) begin
      cycle(1'b1, 1'b0, 1'b0);
      chk("ovf_sticky", {31'd0, o_err}, 32'd1);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if (src.size() < 6 && ($urandom % 3) != 0) src.push_back(4'($urandom));
      cycle(($urandom % 4) != 0, ($urandom % 20) == 0, ($urandom % 80) == 0);
    end

    // Asynchronous reset mid-stream with a full queue.
    src = '{4'd1, 4'd2, 4'd3, 4'd4};
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, o_valid}, 32'd0);
    chk("arst_re", {31'd0, o_re}, 32'd0);
    chk("arst_count", {16'd0, o_count}, 32'd0);
    chk("arst_err", {31'd0, o_err}, 32'd0);
    @(posedge i_clk); #2;
    i_rst = 1'b0;
    model_reset();
    src = '{4'd9};
    cycle(1'b1, 1'b0, 1'b0);
    chk("arst_pop", {31'd0, s_re}, 32'd1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("arst_count_after", {16'd0, s_count}, 32'd1);
    chk("arst_data_after", {28'd0, s_data}, 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
